// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback path.
package regfile_pkg;
   localparam int XLEN     = 32;
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 2 ** REG_AW;

   typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} wb_src_t;
   typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-input arbiter with an alternating priority pointer.
// Defining WB_ARB_FIXED_PRIO_EN makes A always win and removes the pointer.
module rr_arb2
   import regfile_pkg::*;
(
`ifndef WB_ARB_FIXED_PRIO_EN
   input  prio_t prio,
   output prio_t prio_next,
`endif
   input  logic  a_req,
   input  logic  b_req,
   output logic  a_gnt,
   output logic  b_gnt
);
`ifdef WB_ARB_FIXED_PRIO_EN
   assign a_gnt = a_req;
   assign b_gnt = b_req & ~a_req;
`else
   assign a_gnt = a_req & (~b_req | (prio == PRIO_A));
   assign b_gnt = b_req & (~a_req | (prio == PRIO_B));

   // Pointer only moves when both requesters compete.
   always_comb begin
      prio_next = prio;
      if (a_req && b_req)
         prio_next = (prio == PRIO_A) ? PRIO_B : PRIO_A;
   end
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ports A and B and keeps a
// pending-load scoreboard. WB_ARB_FIXED_PRIO_EN selects fixed A priority.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int XLEN   = regfile_pkg::XLEN,
   parameter int REG_AW = regfile_pkg::REG_AW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [REG_AW-1:0]    a_rd,
   input  logic [XLEN-1:0]      a_wd,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [REG_AW-1:0]    b_rd,
   input  logic [XLEN-1:0]      b_wd,
   input  logic                 res_valid,
   input  logic [REG_AW-1:0]    res_rd,
   output logic                 rf_reg_write,
   output logic [REG_AW-1:0]    rf_rd,
   output logic [XLEN-1:0]      rf_wd,
   output logic [2**REG_AW-1:0] busy
);
   localparam int NR = 2 ** REG_AW;

   logic              a_gnt, b_gnt;
   wb_src_t           src;
   logic [REG_AW-1:0] sel_rd;
   logic [XLEN-1:0]   sel_wd;
   logic [NR-1:0]     set_mask, clr_mask, busy_next;

`ifdef WB_ARB_FIXED_PRIO_EN
   rr_arb2 u_arb (
      .a_req (a_valid),
      .b_req (b_valid),
      .a_gnt (a_gnt),
      .b_gnt (b_gnt)
   );
`else
   prio_t prio, prio_next;

   rr_arb2 u_arb (
      .prio      (prio),
      .prio_next (prio_next),
      .a_req     (a_valid),
      .b_req     (b_valid),
      .a_gnt     (a_gnt),
      .b_gnt     (b_gnt)
   );
`endif

   // No handshakes complete while reset is held.
   assign a_ready = a_gnt & ~rst;
   assign b_ready = b_gnt & ~rst;

   assign src    = b_ready ? SRC_B : SRC_A;
   assign sel_rd = (src == SRC_B) ? b_rd : a_rd;
   assign sel_wd = (src == SRC_B) ? b_wd : a_wd;

   // Set is applied after clear so a same-cycle reserve keeps the register busy.
   always_comb begin
      set_mask  = res_valid ? (NR'(1) << res_rd) : '0;
      clr_mask  = b_ready   ? (NR'(1) << b_rd)   : '0;
      busy_next = (busy & ~clr_mask) | set_mask;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_reg_write <= 1'b0;
         rf_rd        <= '0;
         rf_wd        <= '0;
         busy         <= '0;
`ifndef WB_ARB_FIXED_PRIO_EN
         prio         <= PRIO_A;
`endif
      end else begin
         if (a_ready || b_ready) begin
            rf_rd        <= sel_rd;
            rf_wd        <= sel_wd;
            rf_reg_write <= (sel_rd != '0);
         end else begin
            rf_reg_write <= 1'b0;
         end
         busy <= busy_next;
`ifndef WB_ARB_FIXED_PRIO_EN
         prio <= prio_next;
`endif
      end
   end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback requesters: port A (ALU/immediate results) and port B (load/late-return results). Arbitration uses a valid/ready handshake. The block also tracks destination registers with a pending load in a scoreboard, which decode uses for stall decisions. It sits between the execute/memory stages and the `regfile` write inputs (`rd`, `wd`, `reg_write`), and drives those inputs from registered outputs.

## Interface
Parameters:
- `XLEN`, 32, data width of the write value.
- `REG_AW`, 5, register address width; the file has 2**REG_AW registers.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `a_valid`  in  1  port A write request.
- `a_ready`  out  1  port A granted this cycle (combinational).
- `a_rd`  in  REG_AW  port A destination register.
- `a_wd`  in  XLEN  port A write data.
- `b_valid`  in  1  port B write request.
- `b_ready`  out  1  port B granted this cycle (combinational).
- `b_rd`  in  REG_AW  port B destination register.
- `b_wd`  in  XLEN  port B write data.
- `res_valid`  in  1  reserve a register for a future port-B write (load issued).
- `res_rd`  in  REG_AW  register to reserve.
- `rf_reg_write`  out  1  register-file write enable (registered).
- `rf_rd`  out  REG_AW  register-file write address (registered).
- `rf_wd`  out  XLEN  register-file write data (registered).
- `busy`  out  2**REG_AW  scoreboard; bit i set means register i is awaiting a port-B write.

## Operation
- A transfer occurs on a port when its `valid` and `ready` are both high at a rising edge. At most one port is granted per cycle.
- `ready` is a pure function of both `valid` inputs and the priority pointer. It does not depend on its own port's `valid` feeding back through another port's `ready`.
- When one requester is valid, it is granted.
- When both are valid, the pointer decides.
  - Pointer `PRIO_A`: A wins, and the pointer becomes `PRIO_B`.
  - Pointer `PRIO_B`: B wins, and the pointer becomes `PRIO_A`.
  - The pointer changes only on a contested grant.
- Granted request: on the next edge, `rf_rd`/`rf_wd` load the granted `rd`/`wd`, and `rf_reg_write` is 1 unless `rd` is 0.
  - A write to x0 is accepted and consumed, but `rf_reg_write` stays 0.
- No grant: `rf_reg_write` goes to 0. `rf_rd`/`rf_wd` hold their previous values.
- Scoreboard:
  - `res_valid` with `res_rd != 0` sets `busy[res_rd]`.
  - A granted port-B write with `b_rd = i` clears `busy[i]`.
  - `busy[0]` is constant 0. Reservations of x0 are ignored.
- Simultaneous set and clear of the same register in one cycle: set wins, so the register stays busy.
- A re-reservation of an already-busy register is harmless; it stays 1.
- Port-A writes never touch `busy`. WAW ordering against pending loads is the issuing stage's responsibility.

## Timing
- Reset values:
  - `rf_reg_write`=0, `rf_rd`=0, `rf_wd`=0.
  - `busy`=0.
  - Pointer = `PRIO_A`.
  - `a_ready`=`b_ready`=0 while `rst` is high.
- Latency is 1 cycle from handshake edge to `rf_reg_write` high. The `regfile` commits on the following edge, so the value is readable 2 edges after the handshake.
- Throughput is one write per cycle. Back-to-back grants to the same port are allowed.
- A requester holds `valid`, `rd` and `wd` stable until granted. The arbiter never drops a non-granted request.
- `rst` asserted mid-operation: the in-flight registered write is discarded (`rf_reg_write`=0 on the next edge), and all reservations are cleared.
- `busy` updates on the edge of the handshake or reservation and is visible the following cycle.

## Configuration
- `WB_ARB_FIXED_PRIO_EN` defined: fixed priority. A always wins a contest, the pointer is removed, and B is granted only when `a_valid`=0.
- `WB_ARB_FIXED_PRIO_EN` undefined: the round-robin behaviour above.

## Structure
- Shared package `regfile_pkg` holds:
  - `XLEN`, `REG_AW`, `NUM_REGS`.
  - A `wb_src_t` enum (`SRC_A`, `SRC_B`).
  - A `prio_t` enum (`PRIO_A`, `PRIO_B`).
- One sub-module, `rr_arb2`: a two-input arbiter producing grants and the next pointer, with the fixed-priority option. The scoreboard and output register stay in the top.

## Test plan
- Reset, then A alone writes rd=5, wd=42 → `a_ready`=1 in that cycle; next cycle `rf_reg_write`=1, `rf_rd`=5, `rf_wd`=42.
- A and B both valid for 4 cycles (A: rd=1..; B: rd=2..), both holding until granted → grants go A, B, A, B; without the macro each port waits at most 1 cycle. With `WB_ARB_FIXED_PRIO_EN`, A is granted every cycle and `b_ready`=0 throughout.
- A writes rd=0, wd=0xDEADBEEF → `a_ready`=1; next cycle `rf_reg_write`=0.
- `res_valid` with rd=7 → `busy[7]`=1 the next cycle. A write to 7 leaves it at 1. A B write to 7 clears it on the grant edge.
- Same cycle: `res_valid` rd=9 and a granted B write rd=9 with `busy[9]`=1 → `busy[9]` remains 1. A `res_valid` with rd=0 leaves `busy` all-zero.
- `rst` pulsed the cycle after a grant with `busy`=0x0000_0880 → `rf_reg_write`=0, `busy`=0, and the next contested grant goes to A.
